// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and op classification shared by the ALU/MDU.
package alu_pkg;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULTU = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;
  localparam logic [3:0] OP_MFHI  = 4'b1100;
  localparam logic [3:0] OP_MFLO  = 4'b1101;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  function automatic logic is_iterative(input logic [3:0] op);
    return op == OP_MULTU || op == OP_DIVU;
  endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shift-add multiplier / restoring divider, one bit per cycle.
module alu_muldiv_iter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  div_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] hi_o,
  output logic [DATA_WIDTH-1:0] lo_o
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [W-1:0]   m_q, m_d;
  logic           div_q, div_d;
  logic [W:0]     sum, rem, diff;
  logic           ge;
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, m_q} : '0);
    rem   = acc_q[2*W-1:W-1];
    diff  = rem - {1'b0, m_q};
    ge    = rem >= {1'b0, m_q};
    cnt_d = cnt_q;
    acc_d = acc_q;
    m_d   = m_q;
    div_d = div_q;
    if (start_i) begin
      cnt_d = CW'(W);
      div_d = div_i;
      m_d   = div_i ? b_i : a_i;
      acc_d = {{W{1'b0}}, div_i ? a_i : b_i};
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = div_q ? {ge ? diff[W-1:0] : rem[W-1:0], acc_q[W-2:0], ge} : {sum, acc_q[W-1:1]};
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      m_q   <= '0;
      div_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      m_q   <= m_d;
      div_q <= div_d;
    end
  end
  assign done_o = cnt_q == CW'(1);
  assign hi_o   = acc_q[2*W-1:W];
  assign lo_o   = acc_q[W-1:0];
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with iterative MULTU/DIVU and HI/LO registers.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [3:0]             alu_operation_i,
  input  logic [DATA_WIDTH-1:0]  a_i,
  input  logic [DATA_WIDTH-1:0]  b_i,
  input  logic [SHAMT_WIDTH-1:0] shamt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [DATA_WIDTH-1:0]  alu_data_o,
  output logic                   zero_o,
  output logic [DATA_WIDTH-1:0]  hi_o,
  output logic [DATA_WIDTH-1:0]  lo_o
);
  localparam int W = DATA_WIDTH;
  state_t       state_q, state_d;
  logic         done_q, done_d, zero_q, zero_d;
  logic [W-1:0] alu_q, alu_d, hi_q, hi_d, lo_q, lo_d, res, eng_hi, eng_lo;
  logic         div_zero, iter, eng_start, eng_done;
  // divide-by-zero bypasses the engine and completes as a single-cycle op
  assign div_zero  = alu_operation_i == OP_DIVU && b_i == '0;
  assign iter      = is_iterative(alu_operation_i) && !div_zero;
  assign eng_start = state_q == IDLE && start_i && iter;
  alu_muldiv_iter #(.DATA_WIDTH(W)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .start_i(eng_start),
    .div_i  (alu_operation_i == OP_DIVU),
    .a_i    (a_i),
    .b_i    (b_i),
    .done_o (eng_done),
    .hi_o   (eng_hi),
    .lo_o   (eng_lo)
  );
  always_comb begin
    case (alu_operation_i)
      OP_OR:   res = a_i | b_i;
      OP_SLL:  res = b_i << shamt_i;
      OP_ADD:  res = a_i + b_i;
      OP_SUB:  res = a_i - b_i;
      OP_SRL:  res = b_i >> shamt_i;
      OP_AND:  res = a_i & b_i;
      OP_NOR:  res = ~(a_i | b_i);
      OP_SLT:  res = {{(W-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SRA:  res = $signed(b_i) >>> shamt_i;
      OP_DIVU: res = '1;
      OP_MFHI: res = hi_q;
      OP_MFLO: res = lo_q;
      default: res = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    alu_d   = alu_q;
    zero_d  = zero_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: if (start_i) begin
        if (iter) state_d = RUN;
        else begin
          done_d = 1'b1;
          alu_d  = res;
          zero_d = res == '0;
          if (div_zero) begin
            hi_d = a_i;
            lo_d = '1;
          end
        end
      end
      RUN: if (eng_done) state_d = FINISH;
      FINISH: begin
        state_d = IDLE;
        done_d  = 1'b1;
        hi_d    = eng_hi;
        lo_d    = eng_lo;
        alu_d   = eng_lo;
        zero_d  = eng_lo == '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
      alu_q   <= '0;
      zero_q  <= 1'b1;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      alu_q   <= alu_d;
      zero_q  <= zero_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy_o     = state_q != IDLE;
  assign done_o     = done_q;
  assign alu_data_o = alu_q;
  assign zero_o     = zero_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;
endmodule

// File: tb/tb_alu_mdu.sv
// tb_alu_mdu: random and directed checks of alu_mdu against a cycle-level behavioural model.
module tb_alu_mdu;
  localparam int W = 32;
  logic clk = 1'b0, reset = 1'b0;
  always #5 clk = ~clk;
  logic start = 1'b0;
  logic [3:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic [4:0] sh = '0;
  logic busy, done, zero;
  logic [31:0] alu, hi, lo;
  logic start8 = 1'b0;
  logic [3:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [2:0] sh8 = '0;
  logic busy8, done8, zero8;
  logic [7:0] alu8, hi8, lo8;
  int n_cmp = 0, n_bad = 0;

  alu_mdu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start_i(start), .alu_operation_i(op), .a_i(a), .b_i(b),
    .shamt_i(sh), .busy_o(busy), .done_o(done), .alu_data_o(alu), .zero_o(zero), .hi_o(hi), .lo_o(lo)
  );
  alu_mdu #(.DATA_WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start_i(start8), .alu_operation_i(op8), .a_i(a8), .b_i(b8),
    .shamt_i(sh8), .busy_o(busy8), .done_o(done8), .alu_data_o(alu8), .zero_o(zero8), .hi_o(hi8), .lo_o(lo8)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                          input logic [4:0] s, input logic [31:0] h, input logic [31:0] l);
    case (o)
      4'd1:  return x | y;
      4'd2:  return y << s;
      4'd3:  return x + y;
      4'd4:  return x - y;
      4'd5:  return y >> s;
      4'd6:  return x & y;
      4'd7:  return ~(x | y);
      4'd8:  return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd9:  return $signed(y) >>> s;
      4'd12: return h;
      4'd13: return l;
      default: return 32'd0;
    endcase
  endfunction

  // model: count down the cycles until a long op completes; results come from plain arithmetic
  int left = 0;
  logic e_done = 1'b0, e_busy = 1'b0, e_zero = 1'b1;
  logic [31:0] e_alu = '0, e_hi = '0, e_lo = '0, p_hi = '0, p_lo = '0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      left <= 0; e_done <= 1'b0; e_busy <= 1'b0; e_alu <= '0; e_zero <= 1'b1; e_hi <= '0; e_lo <= '0;
    end else if (left > 0) begin
      left   <= left - 1;
      e_busy <= left > 1;
      e_done <= left == 1;
      if (left == 1) begin
        e_hi <= p_hi; e_lo <= p_lo; e_alu <= p_lo; e_zero <= p_lo == 32'd0;
      end
    end else begin
      e_done <= start;
      e_busy <= 1'b0;
      if (start) begin
        if (op == 4'd10 || (op == 4'd11 && b != 32'd0)) begin
          left <= W + 1; e_busy <= 1'b1; e_done <= 1'b0;
          {p_hi, p_lo} <= (op == 4'd10) ? {32'd0, a} * {32'd0, b} : {a % b, a / b};
        end else if (op == 4'd11) begin
          e_hi <= a; e_lo <= '1; e_alu <= '1; e_zero <= 1'b0;
        end else begin
          e_alu  <= ref_alu(op, a, b, sh, e_hi, e_lo);
          e_zero <= ref_alu(op, a, b, sh, e_hi, e_lo) == 32'd0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("done", 64'(done), 64'(e_done));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("alu_data", 64'(alu), 64'(e_alu));
    chk("zero", 64'(zero), 64'(e_zero));
    chk("hi", 64'(hi), 64'(e_hi));
    chk("lo", 64'(lo), 64'(e_lo));
  end

  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s,
                       input int exp_lat, input int exp_busy, input bit poke, input string nm);
    int lat, bc;
    @(posedge clk); #2;
    start = 1'b1; op = o; a = x; b = y; sh = s;
    @(posedge clk); #2;
    start = 1'b0; lat = 1; bc = 0;
    while (!done && lat < 200) begin
      if (busy) bc++;
      if (poke) begin
        start = lat == 5; op = 4'd3; a = 32'd1; b = 32'd1;
      end
      @(posedge clk); #2;
      lat++;
    end
    start = 1'b0;
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
  endtask

  task automatic do_op8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input int exp_lat, input string nm);
    int lat;
    @(posedge clk); #2;
    start8 = 1'b1; op8 = o; a8 = x; b8 = y;
    @(posedge clk); #2;
    start8 = 1'b0; lat = 1;
    while (!done8 && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    chk({nm, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  initial begin
    bit saw_done;
    logic [7:0] x8, y8;
    logic [15:0] p16;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_zero", 64'(zero), 64'd1);
    chk("rst_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("idle_alu", 64'(alu), 64'd0);
    chk("idle_zero", 64'(zero), 64'd1);
    do_op(4'd3, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 0, 1'b0, "add_wrap");
    chk("add_wrap_res", 64'(alu), 64'd0);
    chk("add_wrap_zero", 64'(zero), 64'd1);
    do_op(4'd4, 32'd5, 32'd7, 5'd0, 1, 0, 1'b0, "sub");
    chk("sub_res", 64'(alu), 64'hFFFF_FFFE);
    do_op(4'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 1, 0, 1'b0, "slt");
    chk("slt_res", 64'(alu), 64'd1);
    do_op(4'd9, 32'd0, 32'h8000_0000, 5'd4, 1, 0, 1'b0, "sra");
    chk("sra_res", 64'(alu), 64'hF800_0000);
    do_op(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 34, 33, 1'b1, "multu");
    chk("multu_hi", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'd1);
    chk("multu_model_hi", 64'(e_hi), 64'hFFFF_FFFE);
    do_op(4'd12, 32'd0, 32'd0, 5'd0, 1, 0, 1'b0, "mfhi");
    chk("mfhi_res", 64'(alu), 64'hFFFF_FFFE);
    do_op(4'd11, 32'd100, 32'd7, 5'd0, 34, 33, 1'b0, "divu");
    chk("divu_lo", 64'(lo), 64'd14);
    chk("divu_hi", 64'(hi), 64'd2);
    chk("divu_model_lo", 64'(e_lo), 64'd14);
    do_op(4'd11, 32'd9, 32'd0, 5'd0, 1, 0, 1'b0, "divu0");
    chk("divu0_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("divu0_hi", 64'(hi), 64'd9);
    @(posedge clk); #2;
    start = 1'b1; op = 4'd10; a = 32'h1234_5678; b = 32'h9ABC_DEF1;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    chk("midrun_busy", 64'(busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    saw_done = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #2;
      saw_done |= done;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    do_op(4'd3, 32'd2, 32'd3, 5'd0, 1, 0, 1'b0, "add_after_abort");
    chk("add_after_abort_res", 64'(alu), 64'd5);
    do_op8(4'd10, 8'hFF, 8'hFF, 10, "w8_multu");
    chk("w8_multu_hi", 64'(hi8), 64'hFE);
    chk("w8_multu_lo", 64'(lo8), 64'h01);
    for (int i = 0; i < 12; i++) begin
      x8 = 8'($urandom);
      y8 = (i % 4 == 3) ? 8'd0 : 8'($urandom);
      if (i % 2 == 0) begin
        p16 = {8'd0, x8} * {8'd0, y8};
        do_op8(4'd10, x8, y8, 10, "w8_rand_multu");
        chk("w8_rand_multu_hilo", 64'({hi8, lo8}), 64'(p16));
      end else begin
        do_op8(4'd11, x8, y8, (y8 == 8'd0) ? 1 : 10, "w8_rand_divu");
        chk("w8_rand_divu_lo", 64'(lo8), (y8 == 8'd0) ? 64'hFF : 64'(x8 / y8));
        chk("w8_rand_divu_hi", 64'(hi8), (y8 == 8'd0) ? 64'(x8) : 64'(x8 % y8));
      end
    end
    repeat (3000) begin
      @(posedge clk); #2;
      start = 1'($urandom);
      op = 4'($urandom);
      a = ($urandom % 4 == 0) ? 32'($urandom % 9) : $urandom;
      b = ($urandom % 4 == 0) ? 32'($urandom % 3) : $urandom;
      sh = 5'($urandom);
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
endmodule
